cnt_sweep_ctrl: RTL and testbench
=================================

# cnt_sweep_ctrl

Sequencing controller for the team's 4-bit up/down counter datapath. It owns the count register and drives its direction so that the count sweeps in a triangle pattern between programmable bounds lo and hi, for a programmed number of sweeps. A start/done handshake hands the sweep job in and out. It sits between a configuration master (testbench or control FSM) and any logic that consumes the count.

## Interface
- W, 4, count and bound width
- SW, 4, width of the sweep-count field
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-low; asserting it forces every register to its reset value immediately
- start  in  1  job request, sampled on posedge; accepted only in IDLE
- lo  in  W  lower bound, unsigned, sampled with an accepted start
- hi  in  W  upper bound, unsigned, sampled with an accepted start
- n_sweeps  in  SW  number of full lo→hi→lo sweeps, sampled with an accepted start
- abort  in  1  cancel the current job; sampled on posedge
- cnt  out  W  current count (registered)
- up  out  1  direction: 1 in UP state, 0 otherwise (registered)
- busy  out  1  high in UP and DOWN
- sweep_idx  out  SW  completed sweeps in the current or last job
- done  out  1  one-cycle pulse when the job completes
- err  out  1  one-cycle pulse when a start is rejected for bad config

## Operation
- Reset values: state IDLE, cnt=0, up=0, busy=0, sweep_idx=0, done=0, err=0; latched lo/hi/n_sweeps cleared to 0.
- States: IDLE, UP, DOWN, DONE. Encoding is free.
- IDLE, start=1, lo<hi and n_sweeps≠0: latch the config, cnt←lo, sweep_idx←0, go to UP (up=1, busy=1).
- IDLE, start=1, lo≥hi or n_sweeps=0: err=1 for one cycle, stay in IDLE, cnt and sweep_idx unchanged.
- UP: if cnt==hi_l, go to DOWN and set cnt←hi_l−1. Otherwise cnt←cnt+1.
- DOWN: if cnt==lo_l, set sweep_idx←sweep_idx+1.
  - If the new sweep_idx equals n_sweeps_l, go to DONE and hold cnt at lo_l.
  - Otherwise go to UP and set cnt←lo_l+1.
- DOWN, cnt≠lo_l: cnt←cnt−1.
- DONE: done=1, busy=0, up=0 for exactly one cycle, then IDLE. cnt holds lo_l; sweep_idx holds n_sweeps_l until the next accepted start.
- abort=1 in UP or DOWN: next state IDLE, busy=0, up=0, no done pulse; cnt and sweep_idx freeze at their current values.
- abort in IDLE or DONE has no effect. If abort is high during DONE, the done pulse still fires.
- start while not in IDLE is ignored. This includes the DONE cycle.
- start and abort together in IDLE: start is processed and abort is ignored.
- Arithmetic is unsigned modulo 2^W. Because lo<hi is enforced, cnt never wraps. The full range lo=0, hi=2^W−1 is legal.
- Config inputs are only sampled at an accepted start. Changing them mid-job has no effect.

## Timing
- Let D = hi−lo. If start is accepted at edge 0, then cnt=lo is visible after edge 0.
- cnt reaches hi after edge D. The first sweep completes (cnt=lo in DOWN) after edge 2D.
- Sweep k completes after edge 2kD. DONE (done=1) is visible after edge 2·N·D+1, and IDLE after edge 2·N·D+2.
- busy is high from edge 0 through edge 2·N·D inclusive, i.e. 2·N·D+1 cycles.
- err and done are single-cycle pulses. They never coincide.
- Asynchronous reset mid-job returns all outputs to reset values without waiting for a clock. After rst deasserts, the first accepted start behaves as from a clean IDLE.

## Test plan
- Reset: drive rst=0 mid-clock -> cnt=0, up=0, busy=0, done=0, err=0, sweep_idx=0 immediately.
- Single sweep lo=2, hi=5, N=1 -> cnt sequence 2,3,4,5,4,3,2; up=1 for 4 cycles; done pulse 7 cycles after the start edge; sweep_idx=1.
- Full range lo=0, hi=15, N=3 -> no wrap; cnt=15 exactly 3 times; busy for 91 cycles; done after edge 91; sweep_idx=3.
- Bad config: start with lo=7, hi=7, N=2 -> err=1 for 1 cycle, busy stays 0. Start with lo=3, hi=9, N=0 -> err pulse.
- Abort: lo=1, hi=8, N=2, abort on edge 10 -> IDLE, cnt frozen at 5 (DOWN), sweep_idx=0, no done pulse. A following start is accepted.
- Start while busy: pulse start with new lo/hi on edge 3 -> ignored, job continues with the original bounds. Also assert rst=0 on edge 6 -> immediate reset values.

Source files
------------

// File: rtl/cnt_sweep_ctrl.sv
// Triangle-sweep sequencer for the 4-bit up/down counter datapath.
// Owns the count register and sweeps it lo->hi->lo for n_sweeps passes.
module cnt_sweep_ctrl #(
  parameter int W  = 4,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  lo,
  input  logic [W-1:0]  hi,
  input  logic [SW-1:0] n_sweeps,
  input  logic          abort,
  output logic [W-1:0]  cnt,
  output logic          up,
  output logic          busy,
  output logic [SW-1:0] sweep_idx,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_UP,
    S_DOWN,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [SW-1:0] n_q, n_d;
  logic [SW-1:0] idx_q, idx_d;
  logic          err_q, err_d;
  logic [SW-1:0] idx_inc;

  assign idx_inc = idx_q + SW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    n_d     = n_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (lo < hi && n_sweeps != '0) begin
            lo_d    = lo;
            hi_d    = hi;
            n_d     = n_sweeps;
            cnt_d   = lo;
            idx_d   = '0;
            state_d = S_UP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_UP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == hi_q) begin
          state_d = S_DOWN;
          cnt_d   = hi_q - W'(1);
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end
      S_DOWN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == lo_q) begin
          idx_d = idx_inc;
          // last pass parks the count at lo
          if (idx_inc == n_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_UP;
            cnt_d   = lo_q + W'(1);
          end
        end else begin
          cnt_d = cnt_q - W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cnt       = cnt_q;
  assign up        = (state_q == S_UP);
  assign busy      = (state_q == S_UP) || (state_q == S_DOWN);
  assign sweep_idx = idx_q;
  assign done      = (state_q == S_DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_cnt_sweep_ctrl.sv
// Bench for cnt_sweep_ctrl: closed-form trajectory model,
// directed literal pins, then randomized jobs/aborts/resets.
module tb_cnt_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] lo = '0;
  logic [3:0] hi = '0;
  logic [3:0] n_sweeps = '0;
  logic [3:0] cnt;
  logic       up;
  logic       busy;
  logic [3:0] sweep_idx;
  logic       done;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  bit m_run;
  int m_t, m_lo, m_hi, m_n, m_cnt, m_idx, m_err;

  cnt_sweep_ctrl #(.W(4), .SW(4)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .lo(lo),
    .hi(hi),
    .n_sweeps(n_sweeps),
    .abort(abort),
    .cnt(cnt),
    .up(up),
    .busy(busy),
    .sweep_idx(sweep_idx),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
    end
  endtask

  // Outputs as a function of time since the accepted start.
  task automatic model_out(output int c, output int u, output int b,
                           output int i, output int d);
    int dd, l, p, t;
    c = m_cnt; i = m_idx; u = 0; b = 0; d = 0;
    if (m_run) begin
      dd = m_hi - m_lo;
      l  = 2 * m_n * dd;
      t  = m_t;
      if (t <= l) begin
        p = t % (2 * dd);
        b = 1;
        c = (p <= dd) ? m_lo + p : m_lo + 2 * dd - p;
        u = (t == 0 || (p != 0 && p <= dd)) ? 1 : 0;
        i = (t == 0) ? 0 : (t - 1) / (2 * dd);
      end else begin
        d = 1;
        c = m_lo;
        i = m_n;
      end
    end
  endtask

  task automatic model_step();
    int c, u, b, i, d;
    model_out(c, u, b, i, d);
    m_err = 0;
    if (!m_run) begin
      if (start) begin
        if (lo < hi && n_sweeps != 0) begin
          m_run = 1; m_t = 0;
          m_lo = lo; m_hi = hi; m_n = n_sweeps;
        end else begin
          m_err = 1;
        end
      end
    end else if (d == 1 || abort) begin
      m_run = 0; m_cnt = c; m_idx = i;
    end else begin
      m_t++;
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_t = 0; m_cnt = 0; m_idx = 0; m_err = 0;
    m_lo = 0; m_hi = 0; m_n = 0;
  endtask

  task automatic compare_all();
    int c, u, b, i, d;
    model_out(c, u, b, i, d);
    check("cnt", cnt, c);
    check("up", up, u);
    check("busy", busy, b);
    check("sweep_idx", sweep_idx, i);
    check("done", done, d);
    check("err", err, m_err);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_cnt_lit", cnt, 0);
    check("rst_busy_lit", busy, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int seq[7];
    int exp1[7] = '{2, 3, 4, 5, 4, 3, 2};
    int ups, done_at, busy_n, hi_n, idxd, dones;

    model_reset();
    #3;
    compare_all();
    @(negedge clk);
    rst = 1'b1;

    // single sweep 2..5
    lo = 4'd2; hi = 4'd5; n_sweeps = 4'd1; start = 1'b1;
    cycle();
    start = 1'b0;
    seq[0] = cnt; ups = up; done_at = -1; idxd = -1;
    for (int k = 1; k <= 7; k++) begin
      cycle();
      if (k < 7) seq[k] = cnt;
      ups += up;
      if (done) begin done_at = k; idxd = sweep_idx; end
    end
    for (int k = 0; k < 7; k++) check("sweep_seq", seq[k], exp1[k]);
    check("up_cycles", ups, 4);
    check("done_edge", done_at, 7);
    check("idx_at_done", idxd, 1);
    cycle();

    // full range, three sweeps
    lo = 4'd0; hi = 4'd15; n_sweeps = 4'd3; start = 1'b1;
    cycle();
    start = 1'b0;
    busy_n = busy; hi_n = 0; done_at = -1; idxd = -1;
    for (int k = 1; k <= 95; k++) begin
      cycle();
      busy_n += busy;
      if (busy && cnt == 4'd15) hi_n++;
      if (done) begin done_at = k; idxd = sweep_idx; end
    end
    check("full_busy", busy_n, 91);
    check("full_hits15", hi_n, 3);
    check("full_done_edge", done_at, 91);
    check("full_idx", idxd, 3);

    // bad configurations
    lo = 4'd7; hi = 4'd7; n_sweeps = 4'd2; start = 1'b1;
    cycle();
    start = 1'b0;
    check("err_eq_bounds", err, 1);
    check("err_no_busy", busy, 0);
    cycle();
    check("err_clears", err, 0);
    lo = 4'd3; hi = 4'd9; n_sweeps = 4'd0; start = 1'b1;
    cycle();
    start = 1'b0;
    check("err_zero_n", err, 1);
    cycle();

    // abort during the down leg
    lo = 4'd1; hi = 4'd8; n_sweeps = 4'd2; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 1; k <= 10; k++) cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("abort_cnt", cnt, 5);
    check("abort_busy", busy, 0);
    check("abort_idx", sweep_idx, 0);
    dones = 0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      dones += done;
    end
    check("abort_no_done", dones, 0);
    lo = 4'd4; hi = 4'd6; n_sweeps = 4'd1; start = 1'b1;
    cycle();
    start = 1'b0;
    check("restart_busy", busy, 1);
    for (int k = 0; k < 8; k++) cycle();

    // start while busy is ignored, then async reset
    lo = 4'd3; hi = 4'd6; n_sweeps = 4'd1; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    lo = 4'd0; hi = 4'd15; start = 1'b1;
    cycle();
    start = 1'b0;
    check("busy_start_ign", cnt, 6);
    cycle();
    cycle();
    check("orig_bounds", cnt, 4);
    do_reset();
    lo = 4'd5; hi = 4'd6; n_sweeps = 4'd1; start = 1'b1;
    cycle();
    start = 1'b0;
    check("post_rst_start", cnt, 5);
    for (int k = 0; k < 5; k++) cycle();

    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        start    = 1'b1;
        lo       = 4'($urandom);
        hi       = 4'($urandom);
        n_sweeps = 4'($urandom_range(0, 3));
      end else if ($urandom_range(0, 15) == 0) begin
        lo = 4'($urandom);
        hi = 4'($urandom);
      end
      abort = ($urandom_range(0, 59) == 0);
      cycle();
      start = 1'b0;
      abort = 1'b0;
      if ($urandom_range(0, 599) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
